calc_engine: RTL and testbench
==============================

// Module: calc_engine
// PURPOSE
//   Consumer end of the keypad character stream: takes one ASCII keystroke per key_valid pulse
//   ('0'-'9', '+', '-', '*', '=', 'C', 8'h08 backspace) and runs a two-operand integer calculator.
//   It holds the operand being entered, the accumulator and the pending operator.
//   Sits between the keypad/cursor front end and the display formatter.
// PARAMETERS
//   WIDTH       32  signed datapath width of the accumulator, entry and result (two's complement)
//   MAX_DIGITS  9   max decimal digits per operand; must satisfy 10**MAX_DIGITS-1 <= 2**(WIDTH-1)-1
// PORTS
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous active-low reset
//   key_char      in   8      ASCII keystroke; sampled only when key_valid=1
//   key_valid     in   1      1-cycle strobe; no backpressure; back-to-back strobes are legal
//   disp_value    out  WIDTH  signed value to display
//   disp_err      out  1      1 while in ERROR state
//   op_pending    out  8      ASCII of pending operator ('+','-','*'), 8'h00 if none
//   result_valid  out  1      1-cycle pulse when '=' produces a new result
// BEHAVIOUR
//   - Reset: all outputs 0; state=ENTRY_A; acc=0, entry=0, digit_cnt=0, op=none.
//   - One key per key_valid; all state/outputs update on the next clk edge (latency 1). Keys are never queued.
//   - Unknown chars, including 8'h00, are ignored with no state change.
//   - States: ENTRY_A (first operand), ENTRY_B (second operand), RESULT (showing result), ERROR.
//   - Digit d: entry = entry*10+d and digit_cnt++ if digit_cnt<MAX_DIGITS; else ignored.
//     Leading '0' with digit_cnt=0 keeps entry=0 and does not advance digit_cnt.
//     In RESULT, a digit clears acc/op, sets entry=d, and goes to ENTRY_A.
//   - 8'h08 backspace: if digit_cnt>0, entry = entry/10 and digit_cnt--; else ignored. Ignored in RESULT.
//   - Operator in ENTRY_A: acc=entry (0 if no digits), op=key, clear entry/digit_cnt -> ENTRY_B.
//   - Operator in ENTRY_B, digit_cnt=0: op replaced by the new key.
//   - Operator in ENTRY_B, digit_cnt>0: see CONFIGURATION.
//   - Operator in RESULT: acc kept, op=key -> ENTRY_B (chain from result).
//   - '=' in ENTRY_B with digit_cnt>0: acc = acc op entry; op cleared; result_valid=1 -> RESULT.
//   - '=' in ENTRY_B with digit_cnt=0: ignored.
//   - '=' in ENTRY_A: acc=entry; result_valid=1 -> RESULT.
//   - '=' in RESULT: ignored; no pulse.
//   - Arithmetic: operands sign-extended to 2*WIDTH. Overflow if the result is outside
//     [-2**(WIDTH-1), 2**(WIDTH-1)-1]. On overflow: ERROR, disp_err=1, disp_value=0, no result_valid.
//   - 'C' from any state, ERROR included: same as reset, except outputs update synchronously.
//     In ERROR, every key except 'C' is ignored.
//   - disp_value: entry when digit_cnt>0; otherwise acc in ENTRY_B/RESULT; otherwise 0 in ENTRY_A.
//   - Async reset mid-evaluation: immediate return to reset values; no partial result is visible.
// CONFIGURATION
//   CALC_CHAIN_EN defined: an operator in ENTRY_B with digit_cnt>0 first evaluates acc = acc op entry
//     (overflow -> ERROR), then latches the new op and clears entry. Stays in ENTRY_B; no result_valid.
//   CALC_CHAIN_EN undefined: that keystroke is ignored; the user must press '=' first.
// STRUCTURE
//   calc_pkg: state enum (ST_ENTRY_A, ST_ENTRY_B, ST_RESULT, ST_ERROR); ASCII constants
//     KEY_ADD/SUB/MUL/EQ/CLR/BS; op encoding (OP_NONE/ADD/SUB/MUL).
//   calc_alu sub-module: purely combinational. Inputs: a, b, op. Outputs: WIDTH result and ovf flag.
//   calc_engine keeps the FSM, entry/digit registers and output registers.
// TESTING
//   1 "12+34=" -> result_valid pulse once; disp_value=46; op_pending=0; state RESULT.
//   2 "7-9=" then "*3=" -> -2, then -6; op_pending='*' after the '*' key.
//   3 "99999*99999=" (WIDTH=32) -> disp_err=1, disp_value=0, no result_valid; '5' ignored; 'C' -> all 0.
//   4 "1234",BS,BS,"5" -> 125; ten '9's with MAX_DIGITS=9 -> 999999999 (10th ignored).
//   5 "2+3*4=" -> with CALC_CHAIN_EN: 20; without: '*' ignored, disp_value after '=' = 5*... i.e. "2+34=" = 36.
//   6 Back-to-back key_valid on consecutive cycles ("1","+") plus async rst_n pulse mid-stream -> all outputs 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and keystroke constants for the keypad calculator.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY_A,
        ST_ENTRY_B,
        ST_RESULT,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_e;

    localparam logic [7:0] KEY_ADD = 8'h2B;
    localparam logic [7:0] KEY_SUB = 8'h2D;
    localparam logic [7:0] KEY_MUL = 8'h2A;
    localparam logic [7:0] KEY_EQ  = 8'h3D;
    localparam logic [7:0] KEY_CLR = 8'h43;
    localparam logic [7:0] KEY_BS  = 8'h08;
    localparam logic [7:0] KEY_0   = 8'h30;
    localparam logic [7:0] KEY_9   = 8'h39;

    function automatic op_e key_to_op(input logic [7:0] key);
        case (key)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_NONE;
        endcase
    endfunction

    function automatic logic [7:0] op_to_ascii(input op_e op);
        case (op)
            OP_ADD:  return KEY_ADD;
            OP_SUB:  return KEY_SUB;
            OP_MUL:  return KEY_MUL;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational two-operand ALU; evaluates at double width and flags results
// that do not fit back into WIDTH signed bits.
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  op_e                     i_op,
    output logic signed [WIDTH-1:0] o_result,
    output logic                    o_ovf
);

    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_full;
    logic        [WIDTH:0]     w_top;

    assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};

    always_comb begin
        w_full = w_a_ext;
        case (i_op)
            OP_ADD:  w_full = w_a_ext + w_b_ext;
            OP_SUB:  w_full = w_a_ext - w_b_ext;
            OP_MUL:  w_full = w_a_ext * w_b_ext;
            default: w_full = w_a_ext;
        endcase
    end

    // Fits in WIDTH bits only when the upper half plus the new sign bit all agree.
    assign w_top    = w_full[2*WIDTH-1:WIDTH-1];
    assign o_ovf    = !((&w_top) || (~|w_top));
    assign o_result = w_full[WIDTH-1:0];

endmodule

// File: rtl/calc_engine.sv
// Keypad calculator engine: operand entry, accumulator, pending operator.
// Build option CALC_CHAIN_EN: an operator after a typed second operand evaluates immediately.
//
// state      | meaning
// ST_ENTRY_A | entering first operand
// ST_ENTRY_B | operator latched, entering second operand
// ST_RESULT  | showing result of '='
// ST_ERROR   | overflow, only 'C' is accepted
module calc_engine
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_key_char,
    input  logic                    i_key_valid,
    output logic signed [WIDTH-1:0] o_disp_value,
    output logic                    o_disp_err,
    output logic [7:0]              o_op_pending,
    output logic                    o_result_valid
);

    localparam int             CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_DIGITS);

    state_e                   r_state;
    logic signed [WIDTH-1:0]  r_acc;
    logic        [WIDTH-1:0]  r_entry;
    logic        [CW-1:0]     r_cnt;
    op_e                      r_op;

    state_e                   w_nxt_state;
    logic signed [WIDTH-1:0]  w_nxt_acc;
    logic        [WIDTH-1:0]  w_nxt_entry;
    logic        [CW-1:0]     w_nxt_cnt;
    op_e                      w_nxt_op;
    logic                     w_nxt_rv;
    logic signed [WIDTH-1:0]  w_nxt_disp;

    logic                     w_is_digit;
    logic                     w_is_op;
    logic        [3:0]        w_digit;
    logic signed [WIDTH-1:0]  w_alu_res;
    logic                     w_alu_ovf;

    assign w_is_digit = (i_key_char >= KEY_0) && (i_key_char <= KEY_9);
    assign w_is_op    = (key_to_op(i_key_char) != OP_NONE);
    assign w_digit    = i_key_char[3:0];

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .i_a      (r_acc),
        .i_b      ($signed(r_entry)),
        .i_op     (r_op),
        .o_result (w_alu_res),
        .o_ovf    (w_alu_ovf)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_acc   = r_acc;
        w_nxt_entry = r_entry;
        w_nxt_cnt   = r_cnt;
        w_nxt_op    = r_op;
        w_nxt_rv    = 1'b0;
        if (i_key_valid) begin
            if (i_key_char == KEY_CLR) begin
                w_nxt_state = ST_ENTRY_A;
                w_nxt_acc   = '0;
                w_nxt_entry = '0;
                w_nxt_cnt   = '0;
                w_nxt_op    = OP_NONE;
            end else begin
                case (r_state)
                    ST_ENTRY_A, ST_ENTRY_B: begin
                        if (w_is_digit) begin
                            // A leading zero leaves the operand empty.
                            if (r_cnt < MAX_CNT && !(r_cnt == '0 && w_digit == 4'd0)) begin
                                w_nxt_entry = r_entry * WIDTH'(10) + WIDTH'(w_digit);
                                w_nxt_cnt   = r_cnt + CW'(1);
                            end
                        end else if (i_key_char == KEY_BS) begin
                            if (r_cnt != '0) begin
                                w_nxt_entry = r_entry / WIDTH'(10);
                                w_nxt_cnt   = r_cnt - CW'(1);
                            end
                        end else if (w_is_op) begin
                            if (r_state == ST_ENTRY_A) begin
                                w_nxt_acc   = $signed(r_entry);
                                w_nxt_op    = key_to_op(i_key_char);
                                w_nxt_entry = '0;
                                w_nxt_cnt   = '0;
                                w_nxt_state = ST_ENTRY_B;
                            end else if (r_cnt == '0) begin
                                w_nxt_op = key_to_op(i_key_char);
                            end else begin
`ifdef CALC_CHAIN_EN
                                w_nxt_entry = '0;
                                w_nxt_cnt   = '0;
                                if (w_alu_ovf) begin
                                    w_nxt_state = ST_ERROR;
                                    w_nxt_acc   = '0;
                                    w_nxt_op    = OP_NONE;
                                end else begin
                                    w_nxt_acc = w_alu_res;
                                    w_nxt_op  = key_to_op(i_key_char);
                                end
`endif
                            end
                        end else if (i_key_char == KEY_EQ) begin
                            if (r_state == ST_ENTRY_A) begin
                                w_nxt_acc   = $signed(r_entry);
                                w_nxt_entry = '0;
                                w_nxt_cnt   = '0;
                                w_nxt_rv    = 1'b1;
                                w_nxt_state = ST_RESULT;
                            end else if (r_cnt != '0) begin
                                w_nxt_entry = '0;
                                w_nxt_cnt   = '0;
                                w_nxt_op    = OP_NONE;
                                if (w_alu_ovf) begin
                                    w_nxt_state = ST_ERROR;
                                    w_nxt_acc   = '0;
                                end else begin
                                    w_nxt_acc   = w_alu_res;
                                    w_nxt_rv    = 1'b1;
                                    w_nxt_state = ST_RESULT;
                                end
                            end
                        end
                    end
                    ST_RESULT: begin
                        if (w_is_digit) begin
                            w_nxt_acc   = '0;
                            w_nxt_op    = OP_NONE;
                            w_nxt_entry = WIDTH'(w_digit);
                            w_nxt_cnt   = (w_digit != 4'd0) ? CW'(1) : CW'(0);
                            w_nxt_state = ST_ENTRY_A;
                        end else if (w_is_op) begin
                            w_nxt_op    = key_to_op(i_key_char);
                            w_nxt_state = ST_ENTRY_B;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_nxt_disp = '0;
        if (w_nxt_state != ST_ERROR) begin
            if (w_nxt_cnt != '0)
                w_nxt_disp = $signed(w_nxt_entry);
            else if (w_nxt_state != ST_ENTRY_A)
                w_nxt_disp = w_nxt_acc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_ENTRY_A;
            r_acc          <= '0;
            r_entry        <= '0;
            r_cnt          <= '0;
            r_op           <= OP_NONE;
            o_disp_value   <= '0;
            o_disp_err     <= 1'b0;
            o_op_pending   <= 8'h00;
            o_result_valid <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_acc          <= w_nxt_acc;
            r_entry        <= w_nxt_entry;
            r_cnt          <= w_nxt_cnt;
            r_op           <= w_nxt_op;
            o_disp_value   <= w_nxt_disp;
            o_disp_err     <= (w_nxt_state == ST_ERROR);
            o_op_pending   <= op_to_ascii(w_nxt_op);
            o_result_valid <= w_nxt_rv;
        end
    end

endmodule

// File: tb/tb_calc_engine.sv
// Directed keystroke vectors for calc_engine; expectations hand-computed.
module tb_calc_engine;

    logic               clk;
    logic               rst_n;
    logic [7:0]         key_char;
    logic               key_valid;
    logic signed [31:0] disp_value;
    logic               disp_err;
    logic [7:0]         op_pending;
    logic               result_valid;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [7:0]         key;
        logic               vld;
        logic signed [31:0] val;
        logic               err;
        logic [7:0]         op;
        logic               rv;
    } vec_t;

    vec_t vecs[$];

    calc_engine #(.WIDTH(32), .MAX_DIGITS(9)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_key_char     (key_char),
        .i_key_valid    (key_valid),
        .o_disp_value   (disp_value),
        .o_disp_err     (disp_err),
        .o_op_pending   (op_pending),
        .o_result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [7:0] key, input int val, input logic [7:0] op,
                       input logic rv = 1'b0, input logic err = 1'b0, input logic vld = 1'b1);
        vec_t v;
        v.key = key; v.vld = vld; v.val = val; v.err = err; v.op = op; v.rv = rv;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int val, input logic err,
                         input logic [7:0] op, input logic rv);
        n_vec++;
        if (disp_value !== val || disp_err !== err || op_pending !== op || result_valid !== rv) begin
            n_bad++;
            $display("FAIL %s #%0d: got val=%0d err=%b op=%h rv=%b, want val=%0d err=%b op=%h rv=%b",
                     name, idx, disp_value, disp_err, op_pending, result_valid, val, err, op, rv);
        end
    endtask

    task automatic send(input logic [7:0] key, input logic vld);
        @(negedge clk);
        key_char  = key;
        key_valid = vld;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    initial begin
        int acc9;
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        key_char  = 8'h00;
        key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 12+34=
        add("1", 1, 8'h00); add("2", 12, 8'h00); add("+", 12, "+");
        add("3", 3, "+"); add("4", 34, "+"); add("=", 46, 8'h00, 1'b1);
        add(8'h00, 46, 8'h00, 1'b0, 1'b0, 1'b0);
        add("C", 0, 8'h00);
        // 7-9= then *3=, then '=' in RESULT ignored
        add("7", 7, 8'h00); add("-", 7, "-"); add("9", 9, "-");
        add("=", -2, 8'h00, 1'b1); add("*", -2, "*"); add("3", 3, "*");
        add("=", -6, 8'h00, 1'b1); add("=", -6, 8'h00);
        add("C", 0, 8'h00);
        // 99999*99999= overflows
        add("9", 9, 8'h00); add("9", 99, 8'h00); add("9", 999, 8'h00);
        add("9", 9999, 8'h00); add("9", 99999, 8'h00); add("*", 99999, "*");
        add("9", 9, "*"); add("9", 99, "*"); add("9", 999, "*");
        add("9", 9999, "*"); add("9", 99999, "*");
        add("=", 0, 8'h00, 1'b0, 1'b1);
        add("5", 0, 8'h00, 1'b0, 1'b1);
        add("C", 0, 8'h00);
        // 1234 BS BS 5
        add("1", 1, 8'h00); add("2", 12, 8'h00); add("3", 123, 8'h00);
        add("4", 1234, 8'h00); add(8'h08, 123, 8'h00); add(8'h08, 12, 8'h00);
        add("5", 125, 8'h00);
        add("C", 0, 8'h00);
        // ten 9s, the 10th is ignored
        acc9 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) acc9 = acc9 * 10 + 9;
            add("9", acc9, 8'h00);
        end
        add("C", 0, 8'h00);
        // leading zeros, backspace at empty, '=' from ENTRY_A, digit from RESULT, junk keys
        add("0", 0, 8'h00); add("0", 0, 8'h00); add("7", 7, 8'h00);
        add(8'h08, 0, 8'h00); add(8'h08, 0, 8'h00);
        add("=", 0, 8'h00, 1'b1);
        add("5", 5, 8'h00); add(8'h00, 5, 8'h00); add("x", 5, 8'h00);
        add("-", 5, "-"); add("+", 5, "+"); add("=", 5, "+");
        add("2", 2, "+"); add("=", 7, 8'h00, 1'b1);
        add("C", 0, 8'h00);
        // 2+3*4=
        add("2", 2, 8'h00); add("+", 2, "+"); add("3", 3, "+");
`ifdef CALC_CHAIN_EN
        add("*", 5, "*"); add("4", 4, "*"); add("=", 20, 8'h00, 1'b1);
`else
        add("*", 3, "+"); add("4", 34, "+"); add("=", 36, 8'h00, 1'b1);
`endif
        add("C", 0, 8'h00);

        foreach (vecs[i]) begin
            send(vecs[i].key, vecs[i].vld);
            check("vec", i, vecs[i].val, vecs[i].err, vecs[i].op, vecs[i].rv);
        end

        // back-to-back strobes "1","+"
        @(negedge clk);
        key_char  = "1";
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_char = "+";
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("b2b", 0, 1, 1'b0, "+", 1'b0);

        // async reset mid-stream, asserted away from any clock edge
        @(negedge clk);
        key_char  = "7";
        key_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, 0, 1'b0, 8'h00, 1'b0);
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held", 0, 0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send("3", 1'b1);
        check("post_rst", 0, 3, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
